// File: rtl/pipe_pkg.sv
// Shared types and polarity constants for the pipeline stage family.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic FLUSH_ENABLE = 1'b1;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between a pipeline stage and its neighbours.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occ;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Three-state controller for the two-entry skid stage; drives datapath load enables.
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       load_main,
  output logic       load_skid,
  output logic       sel_skid,
  output logic [1:0] occ
);

  pipe_state_e state_reg, state_next;
  logic        in_xfer;
  logic        out_xfer;

  // Handshake outputs come only from the state flops, so out_ready never reaches in_ready.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign occ       = state_occ(state_reg);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    sel_skid   = 1'b0;
    if (flush == FLUSH_ENABLE) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next = BUSY;
            load_main  = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next = BUSY;
            load_main  = 1'b1;
            sel_skid   = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register stage: two-entry skid buffer (SKID=1) or single-entry register (SKID=0).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID   = 1
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_reg_if.slave bus
);

  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] main_next;
  logic              load_main;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      main_reg <= '0;
    end else if (flush == FLUSH_ENABLE) begin
      main_reg <= '0;
    end else if (load_main) begin
      main_reg <= main_next;
    end
  end

  assign bus.out_data = main_reg;

  generate
    if (SKID != 0) begin : gen_skid
      logic              load_skid;
      logic              sel_skid;
      logic [DATA_W-1:0] skid_reg;

      pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .load_main (load_main),
        .load_skid (load_skid),
        .sel_skid  (sel_skid),
        .occ       (bus.occ)
      );

      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
          skid_reg <= '0;
        end else if (flush == FLUSH_ENABLE) begin
          skid_reg <= '0;
        end else if (load_skid) begin
          skid_reg <= bus.in_data;
        end
      end

      // Draining FULL refills main from the skid entry; otherwise main takes the input.
      assign main_next = sel_skid ? skid_reg : bus.in_data;
    end else begin : gen_single
      logic valid_reg;
      logic ready;
      logic in_xfer;
      logic out_xfer;

      assign ready    = !valid_reg || bus.out_ready;
      assign in_xfer  = bus.in_valid && ready;
      assign out_xfer = valid_reg && bus.out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
          valid_reg <= 1'b0;
        end else if (flush == FLUSH_ENABLE) begin
          valid_reg <= 1'b0;
        end else if (in_xfer) begin
          valid_reg <= 1'b1;
        end else if (out_xfer) begin
          valid_reg <= 1'b0;
        end
      end

      assign load_main     = in_xfer;
      assign main_next     = bus.in_data;
      assign bus.in_ready  = ready;
      assign bus.out_valid = valid_reg;
      assign bus.occ       = {1'b0, valid_reg};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: SKID=1 and SKID=0 stages side by side, checked each cycle against a FIFO-style model.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  bit   armed = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(W)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(W)) bus0 ();

  pipe_stage_reg #(.DATA_W(W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1.slave)
  );
  pipe_stage_reg #(.DATA_W(W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0.slave)
  );

  // Index 1 = skid stage, index 0 = single-entry stage.
  logic         iv   [2];
  logic [W-1:0] id   [2];
  logic         ordy [2];
  logic         ov   [2];
  logic         ir   [2];
  logic [W-1:0] od   [2];
  logic [1:0]   oc   [2];

  assign bus1.in_valid  = iv[1];
  assign bus1.in_data   = id[1];
  assign bus1.out_ready = ordy[1];
  assign bus0.in_valid  = iv[0];
  assign bus0.in_data   = id[0];
  assign bus0.out_ready = ordy[0];
  assign ov[1] = bus1.out_valid;
  assign ir[1] = bus1.in_ready;
  assign od[1] = bus1.out_data;
  assign oc[1] = bus1.occ;
  assign ov[0] = bus0.out_valid;
  assign ir[0] = bus0.in_ready;
  assign od[0] = bus0.out_data;
  assign oc[0] = bus0.occ;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: an ordered buffer of accepted payloads plus the value last shown downstream.
  logic [W-1:0] mbuf  [2][2];
  int           mcnt  [2];
  logic [W-1:0] mlast [2];
  bit           m_acc;
  bit           m_emit;

  function automatic bit model_ready(input int skid, input int cnt, input logic ordy_v);
    if (skid != 0) return cnt < 2;
    return (cnt == 0) || (ordy_v == 1'b1);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mcnt[k]  = 0;
      mlast[k] = '0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k]  = 0;
        mlast[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_acc  = iv[k] && model_ready(k, mcnt[k], ordy[k]);
        m_emit = (mcnt[k] > 0) && ordy[k];
        if (m_emit) begin
          mlast[k]   = mbuf[k][0];
          mbuf[k][0] = mbuf[k][1];
          mcnt[k]    = mcnt[k] - 1;
        end
        if (m_acc) begin
          mbuf[k][mcnt[k]] = id[k];
          mcnt[k]          = mcnt[k] + 1;
        end
      end
    end
  end

  bit           stall_prev [2];
  logic [W-1:0] stall_data [2];

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d_occ", k), W'(oc[k]), W'(mcnt[k]));
        chk($sformatf("dut%0d_out_valid", k), W'(ov[k]), W'(mcnt[k] > 0));
        chk($sformatf("dut%0d_in_ready", k), W'(ir[k]), W'(model_ready(k, mcnt[k], ordy[k])));
        chk($sformatf("dut%0d_out_data", k), od[k], (mcnt[k] > 0) ? mbuf[k][0] : mlast[k]);
        if (stall_prev[k] && rst) chk($sformatf("dut%0d_stall_hold", k), od[k], stall_data[k]);
        stall_prev[k] = ov[k] && !ordy[k] && !flush && rst;
        stall_data[k] = od[k];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1; stall_prev[k] = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_in_ready%0d", k), W'(ir[k]), 32'd1);
      chk($sformatf("rst_out_valid%0d", k), W'(ov[k]), 32'd0);
      chk($sformatf("rst_occ%0d", k), W'(oc[k]), 32'd0);
      chk($sformatf("rst_out_data%0d", k), od[k], 32'd0);
    end
    armed = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Back-to-back stream through the skid stage: one-cycle latency, in_ready never drops.
    for (int i = 1; i <= 8; i++) begin
      iv[1] = 1'b1; id[1] = W'(i);
      cyc();
      chk("stream_data", od[1], W'(i));
      chk("stream_valid", W'(ov[1]), 32'd1);
      chk("stream_ready", W'(ir[1]), 32'd1);
    end
    iv[1] = 1'b0;
    cyc();
    chk("stream_drained", W'(ov[1]), 32'd0);

    // Stall with two entries held, then drain in order.
    iv[1] = 1'b1; id[1] = 32'hA;
    cyc();
    chk("stall_first", od[1], 32'hA);
    id[1] = 32'hB; ordy[1] = 1'b0;
    cyc();
    iv[1] = 1'b0;
    cyc(); cyc();
    chk("stall_occ", W'(oc[1]), 32'd2);
    chk("stall_in_ready", W'(ir[1]), 32'd0);
    chk("stall_data", od[1], 32'hA);
    ordy[1] = 1'b1;
    cyc();
    chk("drain_second", od[1], 32'hB);
    chk("drain_occ", W'(oc[1]), 32'd1);
    cyc();
    chk("drain_empty", W'(ov[1]), 32'd0);

    // Flush from FULL drops both entries and the simultaneous input.
    ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'hA;
    cyc();
    id[1] = 32'hB;
    cyc();
    chk("pre_flush_occ", W'(oc[1]), 32'd2);
    flush = 1'b1; id[1] = 32'hC;
    cyc();
    flush = 1'b0; iv[1] = 1'b0;
    chk("flush_occ", W'(oc[1]), 32'd0);
    chk("flush_valid", W'(ov[1]), 32'd0);
    chk("flush_data", od[1], 32'd0);
    ordy[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_c", W'(ov[1]), 32'd0);
    end

    // Single-entry stage: combinational in_ready follows out_ready.
    iv[0] = 1'b1; id[0] = 32'h5; ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0; id[0] = 32'h6;
    #1;
    chk("single_blocked", W'(ir[0]), 32'd0);
    cyc();
    chk("single_hold", od[0], 32'h5);
    ordy[0] = 1'b1;
    #1;
    chk("single_open", W'(ir[0]), 32'd1);
    cyc();
    chk("single_next", od[0], 32'h6);
    chk("single_valid", W'(ov[0]), 32'd1);
    iv[0] = 1'b0;
    cyc();
    chk("single_empty", W'(ov[0]), 32'd0);

    // Asynchronous reset while holding data.
    ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'hA;
    ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h7;
    cyc();
    id[1] = 32'hB;
    cyc();
    iv[1] = 1'b0; iv[0] = 1'b0;
    chk("prerst_occ", W'(oc[1]), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("arst_in_ready", W'(ir[1]), 32'd1);
    chk("arst_occ", W'(oc[1]), 32'd0);
    chk("arst_valid", W'(ov[1]), 32'd0);
    chk("arst_valid0", W'(ov[0]), 32'd0);
    ordy[1] = 1'b1; ordy[0] = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();
    chk("post_rst_valid1", W'(ov[1]), 32'd0);
    chk("post_rst_valid0", W'(ov[0]), 32'd0);

    // Full throughput with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1'b1; id[k] = $urandom; ordy[k] = 1'b1;
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tput_valid%0d", k), W'(ov[k]), 32'd1);
        chk($sformatf("tput_data%0d", k), od[k], id[k]);
      end
    end

    // Random valid/ready/flush; the per-cycle compare carries the checking.
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 500; i++) begin
        for (int k = 0; k < 2; k++) begin
          iv[k]   = $urandom_range(0, 3) >= (blk % 3);
          id[k]   = $urandom;
          ordy[k] = $urandom_range(0, 3) >= (blk % 4);
        end
        flush = ($urandom_range(0, 63) == 0);
        cyc();
      end
    end
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    cyc(); cyc(); cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width in bits, legal range 1..512.
REQ-002 SHALL have parameter SKID, default 1: 1 selects a two-entry skid stage with state-decoded in_ready; 0 selects a single-entry stage with combinational in_ready.
REQ-003 SHALL have port clk  input  1: single clock; all flops update on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset (`RstEnable == 0).
REQ-005 SHALL have port flush  input  1: synchronous flush; active high (`FlushEnable).
REQ-006 SHALL have port in_valid  input  1: upstream stage presents a payload.
REQ-007 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-008 SHALL have port in_ready  output  1: stage accepts a payload this cycle.
REQ-009 SHALL have port out_valid  output  1: stage presents a payload downstream.
REQ-010 SHALL have port out_data  output  DATA_W: downstream payload, driven directly from the main register.
REQ-011 SHALL have port out_ready  input  1: downstream accepts a payload this cycle (deasserted = stall).
REQ-012 SHALL have port occ  output  2: occupancy, 0..2 (0..1 when SKID=0).

Function
REQ-013 SHALL transfer a payload in when in_valid && in_ready, and out when out_valid && out_ready, both sampled at the clock edge.
REQ-014 SHALL have, for SKID=1, states EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main+skid valid).
REQ-015 SHALL decode in_ready = (state != FULL) and out_valid = (state != EMPTY) from the state flops only, with no combinational path from out_ready to in_ready.
REQ-016 SHALL make these transitions: EMPTY+in -> BUSY (main<=in_data); BUSY+in+out -> BUSY (main<=in_data); BUSY+in only -> FULL (skid<=in_data); BUSY+out only -> EMPTY; FULL+out -> BUSY (main<=skid); any other combination holds state.
REQ-017 SHALL, for SKID=0, use in_ready = !out_valid || out_ready; on an input transfer main<=in_data and out_valid<=1; on an output transfer with no input transfer, out_valid<=0.
REQ-018 SHALL, when flush is high at an edge, go to EMPTY, zero main and skid, and drop any simultaneous input transfer; flush has priority over every handshake.
REQ-019 SHALL keep every accepted payload in order, with no drop and no duplicate; latency in -> out is exactly 1 cycle when the stage is EMPTY.
REQ-020 SHALL sustain 1 transfer per cycle when out_ready is held high, for both SKID values.
REQ-021 SHALL hold out_data stable while out_valid && !out_ready.
REQ-022 SHALL leave main and skid unchanged when no transfer occurs; register writes are enabled only by a transfer or a flush.

Reset
REQ-023 SHALL, while rst is low, force state EMPTY, main = 0, skid = 0, out_valid = 0, and occ = 0.
REQ-024 SHALL drive in_ready = 1 during and after reset (decoded from EMPTY).
REQ-025 SHALL, on reset assertion mid-transfer, lose all held payloads; the first edge after release behaves as EMPTY.

Structure
REQ-026 SHALL take the state enum (EMPTY/BUSY/FULL, 2-bit) from shared package pipe_pkg; RstEnable/FlushEnable come from the existing common defines.
REQ-027 SHALL place the SKID=1 state machine in sub-module pipe_skid_ctrl (outputs: load_main, load_skid, sel_skid, occ), with datapath muxes in pipe_stage_reg.
REQ-028 SHALL use a generate on SKID so that SKID=0 instantiates no skid register.

Verification
REQ-029 SHALL cover this scenario: SKID=1, DATA_W=32, out_ready=1, stream 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after input, and in_ready constant 1.
REQ-030 SHALL cover this scenario: SKID=1, send 0xA, 0xB, then out_ready=0 for 3 cycles -> occ=2, in_ready=0, out_data holds 0xA; on out_ready=1 -> 0xA then 0xB.
REQ-031 SHALL cover this scenario: SKID=1 in FULL (0xA, 0xB), flush=1 with in_valid=1 and in_data=0xC -> next cycle occ=0, out_valid=0, out_data=0, and 0xC never appears.
REQ-032 SHALL cover this scenario: SKID=0, out_ready=0 with main=0x5, in_valid=1 and in_data=0x6 -> in_ready=0 and 0x5 held; on out_ready=1 in the same cycle as in_valid -> 0x6 next cycle.
REQ-033 SHALL cover this scenario: rst pulled low mid-stream in FULL -> out_valid=0, occ=0, and in_ready=1 immediately (asynchronously), with no payload emitted after release.
REQ-034 SHALL cover this scenario: random valid/ready/flush for 10k cycles with a scoreboard -> outputs are in order and equal to inputs minus the flushed entries, and out_data is never changed while stalled.
